// File: rtl/hilo_divider.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU: one 33-bit trial subtraction per cycle,
// 32 iterations, then a sign-fixup cycle that writes HI (remainder) and LO (quotient).
module hilo_divider (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic        Signed,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] Hi,
    output logic [31:0] Lo,
    output logic        DivZero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic        sgn;
    logic        a_neg;
    logic        b_neg;
    logic        dz;
    logic [31:0] a_raw;
    logic [31:0] mag_b;
    logic [31:0] q;
    logic [31:0] r;
    logic [4:0]  count;
    logic [32:0] trial;
    logic [31:0] a_mag;
    logic [31:0] b_mag;

    // 0x80000000 negates to itself, which is exactly the unsigned magnitude we want.
    assign a_mag = (Signed && A[31]) ? -A : A;
    assign b_mag = (Signed && B[31]) ? -B : B;
    assign trial = {r, q[31]} - {1'b0, mag_b};

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (Start) state_nxt = (B == 32'd0) ? FIX : DIV;
            DIV:     if (count == 5'd31) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            sgn     <= 1'b0;
            a_neg   <= 1'b0;
            b_neg   <= 1'b0;
            dz      <= 1'b0;
            a_raw   <= '0;
            mag_b   <= '0;
            q       <= '0;
            r       <= '0;
            count   <= '0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            Hi      <= '0;
            Lo      <= '0;
            DivZero <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        sgn   <= Signed;
                        a_neg <= A[31];
                        b_neg <= B[31];
                        dz    <= (B == 32'd0);
                        a_raw <= A;
                        mag_b <= b_mag;
                        q     <= a_mag;
                        r     <= '0;
                        count <= '0;
                        Busy  <= 1'b1;
                    end
                end
                DIV: begin
                    // R's 33rd bit is always zero after a restore or a successful subtract.
                    if (!trial[32]) begin
                        r <= trial[31:0];
                        q <= {q[30:0], 1'b1};
                    end else begin
                        r <= {r[30:0], q[31]};
                        q <= {q[30:0], 1'b0};
                    end
                    count <= count + 5'd1;
                end
                FIX: begin
                    Busy <= 1'b0;
                    Done <= 1'b1;
                    if (dz) begin
                        Hi      <= a_raw;
                        Lo      <= 32'hFFFF_FFFF;
                        DivZero <= 1'b1;
                    end else begin
                        Lo      <= (sgn && (a_neg ^ b_neg)) ? -q : q;
                        Hi      <= (sgn && a_neg) ? -r : r;
                        DivZero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/hilo_divider.md
# hilo_divider

Multi-cycle integer divider for the MIPS DIV/DIVU instructions, sitting beside the combinational ALU in the execute stage. It reuses the ALU's subtract-and-test principle as one 33-bit trial subtraction per cycle, with restoring division over 32 iterations. Results are written to internal HI (remainder) and LO (quotient) registers. The pipeline holds via `Busy` and reads HI/LO after `Done`.

## Interface
- No parameters; data width fixed at 32.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `Start`  in  1  request a division; sampled only in IDLE.
- `Signed`  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with `Start`.
- `A`  in  32  dividend; sampled with `Start`.
- `B`  in  32  divisor; sampled with `Start`.
- `Busy`  out  1  high while an accepted operation is in progress.
- `Done`  out  1  one-cycle pulse; `Hi`/`Lo` are valid from this cycle.
- `Hi`  out  32  remainder register.
- `Lo`  out  32  quotient register.
- `DivZero`  out  1  last completed operation had `B == 0`.

## Operation
- States: IDLE, DIV, FIX.
- **Accept (IDLE, `Start` = 1):**
  - Latch `Signed`, the sign of `A` and the sign of `B`.
  - Latch magnitudes: `|A|`, `|B|` when `Signed`, else raw values. The magnitude of 0x80000000 is 0x80000000, held unsigned.
  - Set Q = magnitude(A), R = 0 (33 bits), count = 0.
  - If `B == 0`, go to FIX with an internal dz flag set. Otherwise go to DIV.
- **DIV iteration:**
  - trial = {R[31:0], Q[31]} − {1'b0, magnitude(B)}, computed as a 33-bit unsigned subtraction.
  - If trial[32] = 0: R = trial, Q = {Q[30:0], 1}.
  - Else: R = {R[31:0], Q[31]}, Q = {Q[30:0], 0}.
  - count increments each iteration; after the 32nd iteration (count = 31), go to FIX.
- **FIX (normal):**
  - Lo = Q, negated if `Signed` and the operand signs differ.
  - Hi = R[31:0], negated if `Signed` and A was negative.
  - DivZero = 0.
- **FIX (dz):** Hi = A (as latched), Lo = 0xFFFFFFFF, DivZero = 1.
- **FIX (both cases):** `Done` = 1, go to IDLE.
- **Signed overflow:** 0x80000000 / 0xFFFFFFFF gives Lo = 0x80000000, Hi = 0. No flag is raised; this falls out of the algorithm.
- **Result hold:** `Hi`, `Lo` and `DivZero` hold their values until the next FIX.
- **`Start` while not in IDLE:** ignored and not queued. Operands change mid-operation have no effect.
- **Reset (any state, including mid-DIV):** state returns to IDLE. `Busy`, `Done` and `DivZero` go to 0; `Hi`, `Lo`, R, Q and count go to 0. Any in-flight operation is discarded without a `Done`.

## Timing
- All outputs are registered. Reset values: `Busy` = 0, `Done` = 0, `Hi` = 0, `Lo` = 0, `DivZero` = 0.
- Normal operation, with the accepting edge as T:
  - `Busy` rises after T and stays high through the cycle following edge T+32.
  - The DIV iterations occur at edges T+1 … T+32.
  - FIX occurs at edge T+33: `Done` = 1 and `Busy` = 0 in the cycle after T+33; `Hi`/`Lo` are updated at the same edge.
  - Latency from the accepting edge to `Done` is 33 edges.
- Divide-by-zero: FIX occurs at edge T+1, so `Done` is high in the cycle after T+1. `Busy` is high for exactly one cycle.
- `Busy` and `Done` are never high in the same cycle.
- Back-to-back operation: `Start` held high during the `Done` cycle is accepted at the next edge.
- `Done` is high for exactly one cycle per accepted operation.

## Test plan
- **DIVU 100 / 7:**
  - Response: `Done` exactly 33 edges after accept, Lo = 14, Hi = 2, DivZero = 0.
  - `Busy` is high for 33 cycles.
- **DIV −7 / 2 (A = 0xFFFFFFF9, B = 2):** Lo = 0xFFFFFFFD (−3), Hi = 0xFFFFFFFF (−1). Repeat 7 / −2: Lo = 0xFFFFFFFD, Hi = 1.
- **Edge values:**
  - DIVU 0xFFFFFFFF / 1: Lo = 0xFFFFFFFF, Hi = 0.
  - DIV 0x80000000 / 0xFFFFFFFF: Lo = 0x80000000, Hi = 0.
  - DIVU 5 / 9: Lo = 0, Hi = 5.
- **Divide by zero (DIV 0x12345678 / 0):**
  - `Done` one edge after accept, Hi = 0x12345678, Lo = 0xFFFFFFFF, DivZero = 1.
  - A following DIVU 9 / 3 clears DivZero, with Lo = 3, Hi = 0.
- **Start while busy:**
  - Start DIVU 100 / 7, then pulse `Start` with 50 / 5 at edge T+10.
  - Required: a single `Done` at T+33 with Lo = 14, Hi = 2, and no second `Done`.
- **Reset mid-operation:**
  - Assert `reset` at edge T+15.
  - Required: the next cycle has `Busy` = 0, `Done` = 0, Hi = Lo = 0, and `Done` never appears for the aborted operation.
  - A fresh DIVU 100 / 7 then completes normally.
